// File: rtl/moore_seq_det_if.sv
// Serial detector bus: qualified input bit, counter clear, and detect/count results.
// The master drives en, x and clr_cnt; the slave returns y and match_cnt.
interface moore_seq_det_if #(
  parameter int CW = 8
);
  logic          en;
  logic          x;
  logic          clr_cnt;
  logic          y;
  logic [CW-1:0] match_cnt;

  modport master (output en, x, clr_cnt, input y, match_cnt);
  modport slave  (input en, x, clr_cnt, output y, match_cnt);
endinterface

// File: rtl/moore_seq_det.sv
// Parametrised Moore serial pattern detector with a saturating match counter.
// Define MOORE_SEQ_DET_STATE_OUT_EN to add the state_o debug port.
module moore_seq_det #(
  parameter int           N       = 3,
  parameter logic [N-1:0] PATTERN = 3'b101,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CW      = 8,
  parameter int           SW      = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          rst,
`ifdef MOORE_SEQ_DET_STATE_OUT_EN
  output logic [SW-1:0] state_o,
`endif
  moore_seq_det_if.slave det_if
);

  typedef logic [SW-1:0] state_t;

  localparam logic [15:0] PAT16 = 16'(PATTERN);

  // Bit i in arrival order (i = 0 is the first bit of the pattern).
  function automatic bit pbit(input int i);
    int idx;
    idx = N - 1 - i;
    return PAT16[idx[3:0]];
  endfunction

  // Longest suffix of (first k pattern bits, xb) that is also a pattern prefix.
  function automatic int sk_next(input int k, input bit xb);
    int best;
    int p;
    bit ok;
    bit sb;
    best = 0;
    for (int j = k + 1; j >= 1; j--) begin
      if (best == 0) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          p = k + 1 - j + i;
          if (p < k) sb = pbit(p);
          else       sb = xb;
          if (sb != pbit(i)) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  function automatic int border();
    int best;
    bit ok;
    best = 0;
    for (int j = N - 1; j >= 1; j--) begin
      if (best == 0) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          if (pbit(N - j + i) != pbit(i)) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  function automatic int next_of(input int k, input bit xb);
    if (k >= N) return OVERLAP ? sk_next(border(), xb) : sk_next(0, xb);
    return sk_next(k, xb);
  endfunction

  // Next-state table, fully resolved at elaboration.
  state_t ns_x0 [N+1];
  state_t ns_x1 [N+1];

  for (genvar k = 0; k <= N; k++) begin : g_tab
    assign ns_x0[k] = state_t'(next_of(k, 1'b0));
    assign ns_x1[k] = state_t'(next_of(k, 1'b1));
  end

  state_t        cs_q, cs_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q  <= '0;
      cnt_q <= '0;
    end else begin
      cs_q  <= cs_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cs_d  = cs_q;
    cnt_d = cnt_q;
    // Unused encodings recover to S0 whether or not a bit is offered.
    if (cs_q > state_t'(N)) begin
      cs_d = '0;
    end else if (det_if.en) begin
      cs_d = det_if.x ? ns_x1[cs_q] : ns_x0[cs_q];
    end
    if (det_if.clr_cnt) begin
      cnt_d = '0;
    end else if (det_if.en && (cs_d == state_t'(N)) && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign det_if.y         = (cs_q == state_t'(N));
  assign det_if.match_cnt = cnt_q;

`ifdef MOORE_SEQ_DET_STATE_OUT_EN
  assign state_o = cs_q;
`endif

endmodule

// File: tb/tb_moore_seq_det.sv
// Bench for moore_seq_det: five parameterisations driven one at a time,
// checked against a history-window reference model through an expected queue.
module tb_moore_seq_det;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  moore_seq_det_if #(.CW(8)) if0 ();
  moore_seq_det_if #(.CW(8)) if1 ();
  moore_seq_det_if #(.CW(8)) if2 ();
  moore_seq_det_if #(.CW(2)) if3 ();
  moore_seq_det_if #(.CW(8)) if4 ();

`ifdef MOORE_SEQ_DET_STATE_OUT_EN
  logic [1:0] st0, st1, st3;
  logic [2:0] st2, st4;
`endif

  moore_seq_det #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CW(8)) u0 (
    .clk(clk), .rst(rst),
`ifdef MOORE_SEQ_DET_STATE_OUT_EN
    .state_o(st0),
`endif
    .det_if(if0.slave));
  moore_seq_det #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CW(8)) u1 (
    .clk(clk), .rst(rst),
`ifdef MOORE_SEQ_DET_STATE_OUT_EN
    .state_o(st1),
`endif
    .det_if(if1.slave));
  moore_seq_det #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CW(8)) u2 (
    .clk(clk), .rst(rst),
`ifdef MOORE_SEQ_DET_STATE_OUT_EN
    .state_o(st2),
`endif
    .det_if(if2.slave));
  moore_seq_det #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CW(2)) u3 (
    .clk(clk), .rst(rst),
`ifdef MOORE_SEQ_DET_STATE_OUT_EN
    .state_o(st3),
`endif
    .det_if(if3.slave));
  moore_seq_det #(.N(5), .PATTERN(5'b10110), .OVERLAP(1'b1), .CW(8)) u4 (
    .clk(clk), .rst(rst),
`ifdef MOORE_SEQ_DET_STATE_OUT_EN
    .state_o(st4),
`endif
    .det_if(if4.slave));

  int          cfg_n   [5] = '{3, 3, 4, 3, 5};
  logic [15:0] cfg_pat [5] = '{16'h0005, 16'h0005, 16'h000D, 16'h0005, 16'h0016};
  bit          cfg_ov  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int          cfg_max [5] = '{255, 255, 255, 3, 255};

  logic [15:0] m_hist [5];
  int          m_hcnt [5];
  bit          m_y    [5];
  int          m_cnt  [5];

  logic [8:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_hist[i] = '0;
      m_hcnt[i] = 0;
      m_y[i]    = 1'b0;
      m_cnt[i]  = 0;
    end
  endtask

  // Match = the last N accepted bits (since reset, or since the last match
  // when non-overlapping) equal the pattern.
  task automatic model_step(input int id, input bit en, input bit xb, input bit clr);
    logic [15:0] mask;
    bit match;
    mask  = (16'd1 << cfg_n[id]) - 16'd1;
    match = 1'b0;
    if (en) begin
      m_hist[id] = {m_hist[id][14:0], xb};
      if (m_hcnt[id] < cfg_n[id]) m_hcnt[id]++;
      match   = (m_hcnt[id] == cfg_n[id]) && ((m_hist[id] & mask) == cfg_pat[id]);
      m_y[id] = match;
      if (match && !cfg_ov[id]) m_hcnt[id] = 0;
    end
    if (clr) m_cnt[id] = 0;
    else if (match && m_cnt[id] < cfg_max[id]) m_cnt[id]++;
  endtask

  task automatic idle_inputs();
    if0.en = 0; if0.x = 0; if0.clr_cnt = 0;
    if1.en = 0; if1.x = 0; if1.clr_cnt = 0;
    if2.en = 0; if2.x = 0; if2.clr_cnt = 0;
    if3.en = 0; if3.x = 0; if3.clr_cnt = 0;
    if4.en = 0; if4.x = 0; if4.clr_cnt = 0;
  endtask

  task automatic set_inputs(input int id, input bit en, input bit xb, input bit clr);
    idle_inputs();
    case (id)
      0: begin if0.en = en; if0.x = xb; if0.clr_cnt = clr; end
      1: begin if1.en = en; if1.x = xb; if1.clr_cnt = clr; end
      2: begin if2.en = en; if2.x = xb; if2.clr_cnt = clr; end
      3: begin if3.en = en; if3.x = xb; if3.clr_cnt = clr; end
      default: begin if4.en = en; if4.x = xb; if4.clr_cnt = clr; end
    endcase
  endtask

  function automatic logic [8:0] get_act(input int id);
    case (id)
      0: return {if0.y, if0.match_cnt};
      1: return {if1.y, if1.match_cnt};
      2: return {if2.y, if2.match_cnt};
      3: return {if3.y, 6'd0, if3.match_cnt};
      default: return {if4.y, if4.match_cnt};
    endcase
  endfunction

  task automatic drive(input int id, input bit en, input bit xb, input bit clr);
    logic [8:0] act;
    logic [8:0] exp;
    @(negedge clk);
    set_inputs(id, en, xb, clr);
    model_step(id, en, xb, clr);
    exp_q.push_back({m_y[id], 8'(m_cnt[id])});
    @(posedge clk);
    #1;
    act = get_act(id);
    if (exp_q.size() == 0) begin
      chk($sformatf("u%0d_queue", id), 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      chk($sformatf("u%0d_y", id), 32'(act[8]), 32'(exp[8]));
      chk($sformatf("u%0d_cnt", id), 32'(act[7:0]), 32'(exp[7:0]));
    end
  endtask

  task automatic drive_bits(input int id, input logic [15:0] bits, input int len);
    logic [15:0] b;
    b = bits;
    for (int i = len - 1; i >= 0; i--) drive(id, 1'b1, b[i], 1'b0);
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset();
    logic [8:0] act;
    @(negedge clk);
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      act = get_act(i);
      chk($sformatf("u%0d_rst_y", i), 32'(act[8]), 32'd0);
      chk($sformatf("u%0d_rst_cnt", i), 32'(act[7:0]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("u%0d_init_y", i), 32'(get_act(i)), 32'd0);
    end
    rst = 1'b0;

    // 1,0,1,0,1,0,1 overlapping and non-overlapping
    drive_bits(0, 16'b1010101, 7);
    chk("u0_plan_cnt", 32'(if0.match_cnt), 32'd3);
    drive_bits(1, 16'b1010101, 7);
    chk("u1_plan_cnt", 32'(if1.match_cnt), 32'd2);

    // 1101: state parks at S2 on a run of ones
    drive(2, 1'b1, 1'b1, 1'b0);
    drive(2, 1'b1, 1'b1, 1'b0);
    chk("u2_s2_a", 32'(u2.cs_q), 32'd2);
    drive(2, 1'b1, 1'b1, 1'b0);
    chk("u2_s2_b", 32'(u2.cs_q), 32'd2);
    drive_bits(2, 16'b01101, 5);
    chk("u2_plan_cnt", 32'(if2.match_cnt), 32'd2);
    async_reset();
    drive_bits(2, 16'b101101, 6);
    chk("u2_plan_cnt2", 32'(if2.match_cnt), 32'd1);

    // en gaps
    async_reset();
    drive(0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(0, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b0);
    chk("u0_gap_y", 32'(if0.y), 32'd1);

    // partial match lost across reset
    async_reset();
    drive_bits(0, 16'b10, 2);
    async_reset();
    chk("u0_rst_cs", 32'(u0.cs_q), 32'd0);
    drive(0, 1'b1, 1'b1, 1'b0);
    chk("u0_fresh_y", 32'(if0.y), 32'd0);

    // saturating 2-bit counter, then clear on a match edge
    for (int i = 0; i < 6; i++) drive_bits(3, 16'b101, 3);
    chk("u3_sat_cnt", 32'(if3.match_cnt), 32'd3);
    drive_bits(3, 16'b10, 2);
    drive(3, 1'b1, 1'b1, 1'b1);
    chk("u3_clr_y", 32'(if3.y), 32'd1);
    chk("u3_clr_cnt", 32'(if3.match_cnt), 32'd0);

    // random mix across all configurations
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 4), $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end

    // unused encoding recovers to S0 on the next edge
    async_reset();
    @(negedge clk);
    idle_inputs();
    force u4.cs_q = 3'd7;
    #1 release u4.cs_q;
    #1 chk("u4_bad_y", 32'(if4.y), 32'd0);
    @(posedge clk);
    #1 chk("u4_bad_cs", 32'(u4.cs_q), 32'd0);
    drive_bits(4, 16'b1011010110, 10);
    chk("u4_after_cnt", 32'(if4.match_cnt), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
